// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: core load/store port (C) and DMA/loader port (D)
// share one single-ported byte-addressable memory; D may run auto-incrementing bursts.
module dmem_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned MAX_LEN = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          c_req_i,
  input  logic          c_we_i,
  input  logic [AW-1:0] c_addr_i,
  input  logic [31:0]   c_wdata_i,
  input  logic [1:0]    c_mode_i,
  output logic          c_gnt_o,
  output logic          c_rvalid_o,
  output logic [31:0]   c_rdata_o,
  input  logic          d_req_i,
  input  logic          d_we_i,
  input  logic [AW-1:0] d_addr_i,
  input  logic [31:0]   d_wdata_i,
  input  logic [1:0]    d_mode_i,
  input  logic [3:0]    d_len_i,
  output logic          d_gnt_o,
  output logic          d_rvalid_o,
  output logic [31:0]   d_rdata_o,
  output logic          d_done_o,
  output logic          m_we_o,
  output logic [AW-1:0] m_addr_o,
  output logic [31:0]   m_wdata_o,
  output logic [1:0]    m_mode_o,
  input  logic [31:0]   m_rdata_i,
  output logic          err_o
);
  localparam int unsigned CW = $clog2(MAX_LEN);

  typedef enum logic {IDLE, DMA_BURST} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            last_d_q, last_d_d;
  logic            err_q, c_rv_q, d_rv_q;
  logic [31:0]     c_rdata_q, d_rdata_q;

  logic            burst, c_win, d_win, done;
  logic [AW-1:0]   d_addr_eff, step;

  always_comb begin
    burst      = (state_q == DMA_BURST);
    c_win      = 1'b0;
    d_win      = 1'b0;
    // Grants are gated by reset so every output reads as idle while rst_i is high.
    // A burst cycle with d_req_i low is an abort and is arbitrated like IDLE for port C.
    if (!rst_i) begin
      if (burst && d_req_i)                                c_win = 1'b0;
      else if (c_req_i && (!d_req_i || burst || last_d_q)) c_win = 1'b1;
      if (burst && d_req_i)                                d_win = 1'b1;
      else if (d_req_i && !burst && !c_win)                d_win = 1'b1;
    end

    unique case (d_mode_i)
      2'b00:   step = AW'(1);
      2'b01:   step = AW'(2);
      default: step = AW'(4);
    endcase
    d_addr_eff = burst ? addr_q : d_addr_i;
    done       = d_win && (burst ? (cnt_q == CW'(1)) : (d_len_i == 4'd0));

    m_we_o    = 1'b0;
    m_addr_o  = '0;
    m_wdata_o = '0;
    m_mode_o  = 2'b10;
    if (c_win) begin
      m_we_o    = c_we_i && (c_mode_i != 2'b11);
      m_addr_o  = c_addr_i;
      m_wdata_o = c_wdata_i;
      m_mode_o  = c_mode_i;
    end else if (d_win) begin
      m_we_o    = d_we_i && (d_mode_i != 2'b11);
      m_addr_o  = d_addr_eff;
      m_wdata_o = d_wdata_i;
      m_mode_o  = d_mode_i;
    end

    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    last_d_d = last_d_q;
    if (c_win) last_d_d = 1'b0;
    if (d_win) begin
      last_d_d = 1'b1;
      cnt_d    = burst ? (cnt_q - CW'(1)) : CW'(d_len_i);
      addr_d   = d_addr_eff + step;
      if (!burst && d_len_i != 4'd0) state_d = DMA_BURST;
    end
    if (burst && (!d_req_i || done)) begin
      state_d = IDLE;
      if (!d_req_i) cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      last_d_q  <= 1'b1;
      err_q     <= 1'b0;
      c_rv_q    <= 1'b0;
      d_rv_q    <= 1'b0;
      c_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      last_d_q <= last_d_d;
      err_q    <= (c_win && c_mode_i == 2'b11) || (d_win && d_mode_i == 2'b11);
      c_rv_q   <= c_win && !c_we_i && (c_mode_i != 2'b11);
      d_rv_q   <= d_win && !d_we_i && (d_mode_i != 2'b11);
      if (c_win && !c_we_i && (c_mode_i != 2'b11)) c_rdata_q <= m_rdata_i;
      if (d_win && !d_we_i && (d_mode_i != 2'b11)) d_rdata_q <= m_rdata_i;
    end
  end

  assign c_gnt_o    = c_win;
  assign d_gnt_o    = d_win;
  assign d_done_o   = done;
  assign err_o      = err_q;
  assign c_rvalid_o = c_rv_q;
  assign d_rvalid_o = d_rv_q;
  assign c_rdata_o  = c_rdata_q;
  assign d_rdata_o  = d_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus queues expected grants/read data/errors,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_dmem_arbiter;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        c_req_i, c_we_i, d_req_i, d_we_i;
  logic [31:0] c_addr_i, c_wdata_i, d_addr_i, d_wdata_i;
  logic [1:0]  c_mode_i, d_mode_i;
  logic [3:0]  d_len_i;
  logic        c_gnt_o, c_rvalid_o, d_gnt_o, d_rvalid_o, d_done_o, m_we_o, err_o;
  logic [31:0] c_rdata_o, d_rdata_o, m_addr_o, m_wdata_o, m_rdata_i;
  logic [1:0]  m_mode_o;

  dmem_arbiter #(.AW(32), .MAX_LEN(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .c_req_i(c_req_i), .c_we_i(c_we_i), .c_addr_i(c_addr_i), .c_wdata_i(c_wdata_i),
    .c_mode_i(c_mode_i), .c_gnt_o(c_gnt_o), .c_rvalid_o(c_rvalid_o), .c_rdata_o(c_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_mode_i(d_mode_i), .d_len_i(d_len_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o),
    .d_rdata_o(d_rdata_o), .d_done_o(d_done_o), .m_we_o(m_we_o), .m_addr_o(m_addr_o),
    .m_wdata_o(m_wdata_o), .m_mode_o(m_mode_o), .m_rdata_i(m_rdata_i), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  // Byte memory model: asynchronous read (zero-extended), synchronous write.
  logic [7:0] mem [0:255];
  initial for (int i = 0; i < 256; i++) mem[i] = 8'(i);

  always_comb begin
    m_rdata_i = '0;
    unique case (m_mode_o)
      2'b00:   m_rdata_i = {24'd0, mem[m_addr_o[7:0]]};
      2'b01:   m_rdata_i = {16'd0, mem[8'(m_addr_o[7:0] + 8'd1)], mem[m_addr_o[7:0]]};
      default: m_rdata_i = {mem[8'(m_addr_o[7:0] + 8'd3)], mem[8'(m_addr_o[7:0] + 8'd2)],
                            mem[8'(m_addr_o[7:0] + 8'd1)], mem[m_addr_o[7:0]]};
    endcase
  end

  always @(posedge clk_i) begin
    if (m_we_o) begin
      mem[m_addr_o[7:0]] <= m_wdata_o[7:0];
      if (m_mode_o != 2'b00) mem[8'(m_addr_o[7:0] + 8'd1)] <= m_wdata_o[15:8];
      if (m_mode_o == 2'b10) begin
        mem[8'(m_addr_o[7:0] + 8'd2)] <= m_wdata_o[23:16];
        mem[8'(m_addr_o[7:0] + 8'd3)] <= m_wdata_o[31:24];
      end
    end
  end

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct packed {
    logic        port;   // 0 = C, 1 = D
    logic [31:0] addr;
    logic        we;
    logic [1:0]  mode;
    logic        done;
  } gnt_t;

  typedef struct packed {
    logic [31:0] data;
    int          at;
  } rd_t;

  gnt_t gq[$];
  rd_t  cq[$], dq[$];
  int   eq[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_g(input logic port, input logic [31:0] addr, input logic we,
                        input logic [1:0] mode, input logic done);
    gnt_t g;
    g.port = port; g.addr = addr; g.we = we; g.mode = mode; g.done = done;
    gq.push_back(g);
  endtask

  task automatic push_rd(input logic port, input logic [31:0] data, input int at);
    rd_t r;
    r.data = data; r.at = at;
    if (port) dq.push_back(r); else cq.push_back(r);
  endtask

  // Monitor
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (c_gnt_o || d_gnt_o) begin
        check("single_grant", 64'(c_gnt_o && d_gnt_o), 64'd0);
        if (gq.size() == 0) check("unexpected_grant", 64'(1), 64'(0));
        else begin
          gnt_t e, a;
          e = gq.pop_front();
          a.port = d_gnt_o; a.addr = m_addr_o; a.we = m_we_o; a.mode = m_mode_o; a.done = d_done_o;
          check("grant", 64'(a), 64'(e));
        end
      end else if (d_done_o) check("done_without_grant", 64'(1), 64'(0));
      if (c_rvalid_o) begin
        if (cq.size() == 0) check("unexpected_c_rvalid", 64'(1), 64'(0));
        else begin
          rd_t r;
          r = cq.pop_front();
          check("c_rdata", 64'(c_rdata_o), 64'(r.data));
          check("c_rvalid_cycle", 64'(cyc), 64'(r.at));
        end
      end
      if (d_rvalid_o) begin
        if (dq.size() == 0) check("unexpected_d_rvalid", 64'(1), 64'(0));
        else begin
          rd_t r;
          r = dq.pop_front();
          check("d_rdata", 64'(d_rdata_o), 64'(r.data));
          check("d_rvalid_cycle", 64'(cyc), 64'(r.at));
        end
      end
      if (err_o) begin
        if (eq.size() == 0) check("unexpected_err", 64'(1), 64'(0));
        else check("err_cycle", 64'(cyc), 64'(eq.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_c_gnt"}, 64'(c_gnt_o), 64'd0);
    check({tag, "_d_gnt"}, 64'(d_gnt_o), 64'd0);
    check({tag, "_m_we"}, 64'(m_we_o), 64'd0);
    check({tag, "_m_addr"}, 64'(m_addr_o), 64'd0);
    check({tag, "_m_mode"}, 64'(m_mode_o), 64'd2);
    check({tag, "_d_done"}, 64'(d_done_o), 64'd0);
    check({tag, "_err"}, 64'(err_o), 64'd0);
    check({tag, "_rvalid"}, 64'({c_rvalid_o, d_rvalid_o}), 64'd0);
  endtask

  initial begin
    rst_i = 1'b1;
    c_req_i = 1'b1; c_we_i = 1'b1; c_addr_i = 32'h8; c_wdata_i = 32'h1; c_mode_i = 2'b10;
    d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h8; d_wdata_i = 32'h2; d_mode_i = 2'b10;
    d_len_i = 4'd0;
    #3;
    check_idle_outputs("reset");
    check("reset_rdata", 64'({c_rdata_o, d_rdata_o}), 64'd0);
    c_req_i = 1'b0; d_req_i = 1'b0;
    tick(); tick();
    rst_i = 1'b0;
    #1;
    check_idle_outputs("post_reset");

    // Tie from reset: C, D, C, D
    c_req_i = 1'b1; c_we_i = 1'b0; c_addr_i = 32'h8; c_mode_i = 2'b10;
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h8; d_mode_i = 2'b10; d_len_i = 4'd0;
    push_g(0, 32'h8, 0, 2'b10, 0); push_rd(0, 32'h0B0A0908, cyc + 1);
    push_g(1, 32'h8, 0, 2'b10, 1); push_rd(1, 32'h0B0A0908, cyc + 2);
    push_g(0, 32'h8, 0, 2'b10, 0); push_rd(0, 32'h0B0A0908, cyc + 3);
    push_g(1, 32'h8, 0, 2'b10, 1); push_rd(1, 32'h0B0A0908, cyc + 4);
    repeat (4) tick();
    c_req_i = 1'b0; d_req_i = 1'b0;
    tick();

    // Lone core word write then read
    c_req_i = 1'b1; c_we_i = 1'b1; c_addr_i = 32'h8; c_wdata_i = 32'hDEADBEEF; c_mode_i = 2'b10;
    push_g(0, 32'h8, 1, 2'b10, 0);
    tick();
    c_we_i = 1'b0;
    push_g(0, 32'h8, 0, 2'b10, 0); push_rd(0, 32'hDEADBEEF, cyc + 1);
    tick();
    c_req_i = 1'b0;
    tick();

    // DMA halfword write burst, core waits until the burst ends
    d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h10; d_mode_i = 2'b01; d_len_i = 4'd3;
    d_wdata_i = 32'h1111;
    push_g(1, 32'h10, 1, 2'b01, 0);
    tick();
    d_wdata_i = 32'h2222;
    c_req_i = 1'b1; c_we_i = 1'b0; c_addr_i = 32'h12; c_mode_i = 2'b01;
    push_g(1, 32'h12, 1, 2'b01, 0);
    tick();
    d_wdata_i = 32'h3333;
    push_g(1, 32'h14, 1, 2'b01, 0);
    tick();
    d_wdata_i = 32'h4444;
    push_g(1, 32'h16, 1, 2'b01, 1);
    tick();
    d_req_i = 1'b0;
    push_g(0, 32'h12, 0, 2'b01, 0); push_rd(0, 32'h00002222, cyc + 1);
    tick();
    c_req_i = 1'b0;
    tick();

    // Burst abort after beat 2; pending core request takes the abort cycle
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h20; d_mode_i = 2'b10; d_len_i = 4'd7;
    push_g(1, 32'h20, 0, 2'b10, 0); push_rd(1, 32'h23222120, cyc + 1);
    tick();
    c_req_i = 1'b1; c_we_i = 1'b0; c_addr_i = 32'h14; c_mode_i = 2'b01;
    push_g(1, 32'h24, 0, 2'b10, 0); push_rd(1, 32'h27262524, cyc + 1);
    tick();
    d_req_i = 1'b0;
    push_g(0, 32'h14, 0, 2'b01, 0); push_rd(0, 32'h00003333, cyc + 1);
    tick();
    c_req_i = 1'b0;
    d_req_i = 1'b1; d_addr_i = 32'h40; d_len_i = 4'd0;
    push_g(1, 32'h40, 0, 2'b10, 1); push_rd(1, 32'h43424140, cyc + 1);
    tick();
    d_req_i = 1'b0;
    tick();

    // Illegal mode write: granted, no write, err next cycle
    c_req_i = 1'b1; c_we_i = 1'b1; c_addr_i = 32'h30; c_wdata_i = 32'hFFFFFFFF; c_mode_i = 2'b11;
    push_g(0, 32'h30, 0, 2'b11, 0); eq.push_back(cyc + 1);
    tick();
    c_we_i = 1'b0; c_mode_i = 2'b10;
    push_g(0, 32'h30, 0, 2'b10, 0); push_rd(0, 32'h33323130, cyc + 1);
    tick();
    c_req_i = 1'b0;
    tick();

    // Reset during beat 3 of an 8-beat burst
    d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h50; d_mode_i = 2'b10; d_len_i = 4'd7;
    d_wdata_i = 32'h11111111;
    push_g(1, 32'h50, 1, 2'b10, 0);
    tick();
    d_wdata_i = 32'h22222222;
    push_g(1, 32'h54, 1, 2'b10, 0);
    tick();
    d_wdata_i = 32'h33333333;
    c_req_i = 1'b1; c_we_i = 1'b0; c_addr_i = 32'h8; c_mode_i = 2'b10;
    #1 rst_i = 1'b1;
    #1;
    check_idle_outputs("mid_burst_reset");
    tick(); tick();
    d_we_i = 1'b0; d_len_i = 4'd0;
    rst_i = 1'b0;
    push_g(0, 32'h8, 0, 2'b10, 0);  push_rd(0, 32'hDEADBEEF, cyc + 1);
    push_g(1, 32'h50, 0, 2'b10, 1); push_rd(1, 32'h11111111, cyc + 2);
    tick();
    c_req_i = 1'b0;
    tick();
    d_req_i = 1'b0;
    repeat (3) tick();

    check("grants_left", 64'(gq.size()), 64'd0);
    check("c_reads_left", 64'(cq.size()), 64'd0);
    check("d_reads_left", 64'(dq.size()), 64'd0);
    check("errs_left", 64'(eq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
